// File: rtl/sad_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sad_search_ctrl
//  Brief    : Block-matching search controller. Issues a fixed list of
//             candidate blocks to the 4x8 SAD datapath, follows each issue
//             through the datapath latency with a token pipe, and keeps the
//             minimum SAD and the index of the candidate that produced it.
//  Revision : 1.0 - initial release
// ============================================================================
module sad_search_ctrl #(
    parameter int WIDTH    = 8,   // pixel width
    parameter int NUM_CAND = 16,  // candidates per search (>= 1)
    parameter int IDX_W    = 4,   // candidate index width, 2**IDX_W >= NUM_CAND
    parameter int SAD_LAT  = 2    // cycles from sad_en to the matching sad_in
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cand_valid,
    output logic [IDX_W-1:0]   cand_idx,
    output logic               sad_en,
    input  logic [WIDTH+4:0]   sad_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH+4:0]   best_sad,
    output logic [IDX_W-1:0]   best_idx
);

    // Index of the final candidate; issuing it ends the ISSUE phase.
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;

    // Issue counter; doubles as the registered cand_idx output.
    logic [IDX_W-1:0]              r_cnt;

    // Token pipe: one slot per cycle of datapath latency. A valid token at
    // the last stage means sad_in currently carries that candidate's SAD.
    logic [SAD_LAT-1:0]            r_tok_vld;
    logic [SAD_LAT-1:0][IDX_W-1:0] r_tok_idx;
    logic [SAD_LAT-1:0]            w_vld_shift;
    logic [SAD_LAT-1:0][IDX_W-1:0] w_idx_shift;

    logic [WIDTH+4:0]              r_best_sad;
    logic [IDX_W-1:0]              r_best_idx;

    logic                          w_accept;
    logic                          w_issue;
    logic                          w_last_issue;
    logic                          w_pipe_empty_nxt;
    logic                          w_out_vld;
    logic [IDX_W-1:0]              w_out_idx;
    logic                          w_better;

    // A start is only honoured from IDLE; elsewhere it is dropped.
    assign w_accept     = (r_state == S_IDLE) && start;
    // A candidate is issued in every ISSUE cycle where fetch has data ready.
    assign w_issue      = (r_state == S_ISSUE) && cand_valid;
    assign w_last_issue = w_issue && (r_cnt == c_LAST_IDX);

    // Last pipe stage lines up with the datapath output for this cycle.
    assign w_out_vld    = r_tok_vld[SAD_LAT-1];
    assign w_out_idx    = r_tok_idx[SAD_LAT-1];
    // Strict compare so that ties keep the earlier (lower) index.
    assign w_better     = w_out_vld && (sad_in < r_best_sad);

    assign cand_idx     = r_cnt;
    assign best_sad     = r_best_sad;
    assign best_idx     = r_best_idx;

    // Next contents of the token pipe: new token in, everything moves one on.
    always_comb begin
        w_vld_shift    = '0;
        w_idx_shift    = '0;
        w_vld_shift[0] = w_issue;
        w_idx_shift[0] = r_cnt;
        for (int k = 1; k < SAD_LAT; k++) begin
            w_vld_shift[k] = r_tok_vld[k-1];
            w_idx_shift[k] = r_tok_idx[k-1];
        end
    end

    // DRAIN ends once the shifted pipe no longer carries any issued candidate.
    assign w_pipe_empty_nxt = (w_vld_shift == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        sad_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy   = 1'b1;
                sad_en = cand_valid;
                if (w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_pipe_empty_nxt) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Issue counter: holds on stalls, returns to zero after the last issue
    // so cand_idx rests at 0 outside a search.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            if (w_last_issue) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + IDX_W'(1);
            end
        end
    end

    // Token pipe shifts every cycle; stalls and DRAIN insert empty tokens.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tok_vld <= '0;
            r_tok_idx <= '0;
        end else begin
            r_tok_vld <= w_vld_shift;
            r_tok_idx <= w_idx_shift;
        end
    end

    // Best-match tracking: seeded to all ones on accept, then lowered by
    // each returning SAD. Values persist between searches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_sad <= '0;
            r_best_idx <= '0;
        end else if (w_accept) begin
            r_best_sad <= '1;
            r_best_idx <= '0;
        end else if (w_better) begin
            r_best_sad <= sad_in;
            r_best_idx <= w_out_idx;
        end
    end

endmodule
`default_nettype wire

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
- Sequences a fixed list of candidate blocks through the 4x8 SAD datapath. The datapath has 32 pixel pairs, 2-cycle latency, and `en`-gated input registers.
- Tracks the minimum SAD and the index of the candidate that produced it.
- Sits between the candidate-fetch logic, which supplies `cand_idx` data and `cand_valid`, and the SAD unit, whose `en` it drives and whose `out_sad` it reads.
- Reports one best-match result per search with a `done` pulse.

Parameters:
- WIDTH, 8: pixel width; SAD result width is WIDTH+5.
- NUM_CAND, 16: candidates per search (≥1).
- IDX_W, 4: candidate index width; must satisfy 2^IDX_W ≥ NUM_CAND.
- SAD_LAT, 2: cycles from `sad_en` asserted to the matching `sad_in` being valid.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a search; sampled only in IDLE.
- cand_valid  in  1  candidate `cand_idx` data is present on the SAD inputs this cycle.
- cand_idx  out  IDX_W  index of the candidate currently requested.
- sad_en  out  1  drives SAD unit `en`.
- sad_in  in  WIDTH+5  SAD unit `out_sad`.
- busy  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- done  out  1  one-cycle pulse; `best_*` is valid from this cycle on.
- best_sad  out  WIDTH+5  minimum SAD of the last completed search.
- best_idx  out  IDX_W  candidate index of `best_sad`.

Behaviour:
- Reset values:
  - state = IDLE.
  - `cand_idx`, `sad_en`, `busy`, `done` = 0.
  - `best_sad` = 0, `best_idx` = 0.
  - Latency pipe cleared; issue counter = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - When `start`=1: go to ISSUE; issue counter <= 0; `best_sad` <= all ones; `best_idx` <= 0.
- ISSUE:
  - `cand_idx` = issue counter (registered output).
  - `sad_en` = `cand_valid`, combinational, asserted only in ISSUE.
  - When `cand_valid`=1:
    - push token {valid=1, idx=counter} into a SAD_LAT-deep shift pipe;
    - counter increments.
  - When `cand_valid`=0: push an invalid token and hold the counter. This is a stall; there is no timeout.
  - On the issue of index NUM_CAND-1: go to DRAIN.
- DRAIN:
  - `sad_en` = 0; invalid tokens are pushed.
  - When the pipe holds no valid token after the shift: go to DONE. This means DRAIN lasts exactly SAD_LAT cycles.
- DONE:
  - `done` = 1 for one cycle, `busy` = 1.
  - Next state is IDLE.
  - A `start` in this cycle is ignored.
- Compare rule (any state):
  - Applies when the pipe output token is valid, i.e. the candidate was issued exactly SAD_LAT cycles earlier.
  - If `sad_in` < `best_sad`, unsigned and strict: `best_sad` <= `sad_in`, `best_idx` <= token idx.
  - Ties keep the earlier, lower index.
  - The comparison for the last candidate completes on the final DRAIN edge, so `best_*` is stable when `done` is high.
- Best register hold:
  - `best_sad` and `best_idx` hold their values between searches.
  - A new search overwrites them only at the IDLE→ISSUE transition.
- Start handling:
  - `start` while `busy` is ignored; it is not queued.
- Issue throughput:
  - One candidate per cycle when `cand_valid` stays high.
  - Search length with no stalls = 1 (accept) + NUM_CAND + SAD_LAT + 1 (DONE) cycles.
- Width: the SAD result for 32×(2^WIDTH−1) fits in WIDTH+5 bits, so no saturation is needed.
- `rst` asserted mid-search:
  - Aborts the search on that edge and clears the pipe.
  - Returns all outputs to their reset values next cycle.
  - No `done` is produced.

Test Plan:
- Reset, then idle with `start`=0 for 10 cycles → `busy`=0, `done`=0, `sad_en`=0, `best_sad`=0, `best_idx`=0 throughout.
- NUM_CAND=16, `cand_valid` held 1, SAD model returns 100+16·|i−5| for candidate i → `sad_en` high 16 consecutive cycles; `done` 20 cycles after the `start` edge; `best_sad`=100, `best_idx`=5.
- `cand_valid` low on alternate cycles, same SAD model → 16 `sad_en` pulses; `cand_idx` holds during stalls; result `best_sad`=100, `best_idx`=5; `done` 15 cycles later than in the no-stall case.
- All candidates return SAD 42 → `best_sad`=42, `best_idx`=0 (tie rule). Next candidate set all 8160 → `best_sad`=8160, `best_idx`=0 (all-ones init replaced).
- `start` pulsed during ISSUE and during DONE → ignored; exactly one `done` per accepted `start`.
- `rst` asserted at the 7th ISSUE cycle → next cycle IDLE, `busy`=0, `best_sad`=0, no `done`. A new `start` then completes normally with correct results.
